// File: rtl/weight_seq_ctrl.sv
// Weight-store fetch sequencer: walks LAYER0..LAYER3 then AFFINE, phase by
// phase, handshaking with the store (load/valid) and the consumer (rdy/ack).
`ifndef LAYER0
`define LAYER0 4'd0
`endif
`ifndef LAYER1
`define LAYER1 4'd1
`endif
`ifndef LAYER2
`define LAYER2 4'd2
`endif
`ifndef LAYER3
`define LAYER3 4'd3
`endif
`ifndef AFFINE
`define AFFINE 4'd4
`endif

module weight_seq_ctrl #(
    parameter int N_PHASE_CONV = 8,
    parameter int N_PHASE_AFF  = 2,
    parameter int TIMEOUT      = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       ws_valid,
    output logic       ws_load,
    output logic [3:0] ws_cs,
    output logic [2:0] ws_phase,
    output logic       w_rdy,
    input  logic       w_ack,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        HOLD,
        FIN
    } state_t;

    localparam logic [2:0] LAST_LAYER   = 3'd4;
    localparam logic [2:0] LAST_CONV_PH = 3'(N_PHASE_CONV - 1);
    localparam logic [2:0] LAST_AFF_PH  = 3'(N_PHASE_AFF - 1);
    localparam logic [7:0] FETCH_MIN    = 8'd2;
    localparam logic [7:0] FETCH_MAX    = 8'(TIMEOUT);

    state_t     state, state_n;
    logic [2:0] layer, layer_n;
    logic [2:0] phase, phase_n;
    logic [7:0] fcnt, fcnt_n;
    logic       err_n;
    logic [2:0] last_ph;

    logic       ws_load_n;
    logic       w_rdy_n;
    logic       busy_n;
    logic       done_n;
    logic [3:0] ws_cs_n;
    logic [2:0] ws_phase_n;

    function automatic logic [3:0] layer_code(input logic [2:0] l);
        logic [3:0] c;
        case (l)
            3'd0:    c = `LAYER0;
            3'd1:    c = `LAYER1;
            3'd2:    c = `LAYER2;
            3'd3:    c = `LAYER3;
            default: c = `AFFINE;
        endcase
        return c;
    endfunction

    // Next-state and next-output logic; outputs are a function of the
    // state being entered so that every port comes straight from a flop.
    always_comb begin
        state_n = state;
        layer_n = layer;
        phase_n = phase;
        fcnt_n  = fcnt;
        err_n   = err;
        last_ph = (layer == LAST_LAYER) ? LAST_AFF_PH : LAST_CONV_PH;

        if (abort && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = SETUP;
                        err_n   = 1'b0;
                        layer_n = 3'd0;
                        phase_n = 3'd0;
                    end
                end
                SETUP: begin
                    state_n = FETCH;
                    fcnt_n  = 8'd0;
                end
                FETCH: begin
                    // Store valid is stale until its init cycle completes
                    if (ws_valid && fcnt >= FETCH_MIN) begin
                        state_n = HOLD;
                    end else if (fcnt == FETCH_MAX) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else begin
                        fcnt_n = fcnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (w_ack) begin
                        if (phase != last_ph) begin
                            phase_n = phase + 3'd1;
                            state_n = SETUP;
                        end else if (layer != LAST_LAYER) begin
                            phase_n = 3'd0;
                            layer_n = layer + 3'd1;
                            state_n = SETUP;
                        end else begin
                            state_n = FIN;
                        end
                    end
                end
                FIN: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (state_n == IDLE) begin
            layer_n = 3'd0;
            phase_n = 3'd0;
            fcnt_n  = 8'd0;
        end

        ws_load_n  = (state_n == FETCH) || (state_n == HOLD);
        w_rdy_n    = (state_n == HOLD);
        busy_n     = (state_n != IDLE);
        done_n     = (state_n == FIN);
        ws_cs_n    = layer_code(layer_n);
        ws_phase_n = phase_n;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            layer    <= 3'd0;
            phase    <= 3'd0;
            fcnt     <= 8'd0;
            err      <= 1'b0;
            ws_load  <= 1'b0;
            w_rdy    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ws_cs    <= `LAYER0;
            ws_phase <= 3'd0;
        end else begin
            state    <= state_n;
            layer    <= layer_n;
            phase    <= phase_n;
            fcnt     <= fcnt_n;
            err      <= err_n;
            ws_load  <= ws_load_n;
            w_rdy    <= w_rdy_n;
            busy     <= busy_n;
            done     <= done_n;
            ws_cs    <= ws_cs_n;
            ws_phase <= ws_phase_n;
        end
    end

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed bench for weight_seq_ctrl: reset, latency, stale valid, abort,
// full sequence with store/consumer model, timeout, async reset mid-run.
`ifndef LAYER0
`define LAYER0 4'd0
`endif
`ifndef LAYER1
`define LAYER1 4'd1
`endif
`ifndef LAYER2
`define LAYER2 4'd2
`endif
`ifndef LAYER3
`define LAYER3 4'd3
`endif
`ifndef AFFINE
`define AFFINE 4'd4
`endif

module tb_weight_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ws_valid = 1'b0;
    logic       w_ack = 1'b0;
    logic       ws_load;
    logic [3:0] ws_cs;
    logic [2:0] ws_phase;
    logic       w_rdy;
    logic       busy;
    logic       done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;
    int lcnt  = 0;
    int rcnt  = 0;

    weight_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .ws_valid (ws_valid),
        .ws_load  (ws_load),
        .ws_cs    (ws_cs),
        .ws_phase (ws_phase),
        .w_rdy    (w_rdy),
        .w_ack    (w_ack),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_cs(input int v);
        logic [3:0] c;
        case (v / 8)
            0:       c = `LAYER0;
            1:       c = `LAYER1;
            2:       c = `LAYER2;
            3:       c = `LAYER3;
            default: c = `AFFINE;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] exp_ph(input int v);
        return (v < 32) ? 3'(v % 8) : 3'(v - 32);
    endfunction

    // Store raises valid on the 7th load cycle; consumer acks on 4th rdy cycle
    task automatic model();
        if (ws_load) lcnt++; else lcnt = 0;
        ws_valid = (lcnt > 6);
        if (w_rdy) rcnt++; else rcnt = 0;
        w_ack = (rcnt > 3);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_load"}, ws_load, 0);
        chk({tag, "_rdy"}, w_rdy, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cs"}, ws_cs, `LAYER0);
        chk({tag, "_ph"}, ws_phase, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hv;
        int low_run;
        int n_setup;
        int done_cnt;
        int reached;
        logic prev_rdy;

        // Reset values
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("rst");
        #6 rst = 1'b0;
        step();

        // Start-to-load latency
        start = 1'b1;
        step();
        start = 1'b0;
        chk("lat_setup_busy", busy, 1);
        chk("lat_setup_load", ws_load, 0);
        step();
        chk("lat_fetch_load", ws_load, 1);
        chk("lat_fetch_cs", ws_cs, `LAYER0);

        // Stale valid held through FETCH entry
        ws_valid = 1'b1;
        step();
        chk("stale_c1_rdy", w_rdy, 0);
        step();
        chk("stale_c2_rdy", w_rdy, 0);
        step();
        chk("stale_hold_rdy", w_rdy, 1);
        chk("stale_hold_ph", ws_phase, 0);
        w_ack = 1'b1;
        step();
        w_ack = 1'b0;
        chk("adv_setup_rdy", w_rdy, 0);
        chk("adv_setup_load", ws_load, 0);
        chk("adv_setup_ph", ws_phase, 1);
        step();
        chk("stale2_c0_load", ws_load, 1);
        chk("stale2_c0_rdy", w_rdy, 0);
        step();
        chk("stale2_c1_rdy", w_rdy, 0);
        step();
        chk("stale2_c2_rdy", w_rdy, 0);
        step();
        chk("stale2_hold_rdy", w_rdy, 1);
        chk("stale2_hold_ph", ws_phase, 1);

        // Abort beats ack in HOLD
        abort = 1'b1;
        w_ack = 1'b1;
        step();
        abort = 1'b0;
        w_ack = 1'b0;
        ws_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rdy", w_rdy, 0);
        chk("abort_load", ws_load, 0);
        chk("abort_done", done, 0);
        chk("abort_ph", ws_phase, 0);
        step();
        chk("abort_after_done", done, 0);
        chk("abort_after_busy", busy, 0);

        // Full sequence
        start = 1'b1;
        step();
        start = 1'b0;
        hv = 0;
        low_run = 0;
        n_setup = 0;
        done_cnt = 0;
        prev_rdy = 1'b0;
        lcnt = 0;
        rcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (busy && !ws_load && !done) begin
                low_run++;
                chk("setup_sel", {ws_cs, ws_phase}, {exp_cs(hv), exp_ph(hv)});
            end
            if (ws_load && low_run != 0) begin
                chk("setup_len", low_run, 1);
                n_setup++;
                low_run = 0;
            end
            if (w_rdy && !prev_rdy) begin
                chk("hold_sel", {ws_cs, ws_phase}, {exp_cs(hv), exp_ph(hv)});
                hv++;
            end
            prev_rdy = w_rdy;
            if (done) begin
                done_cnt++;
                break;
            end
            model();
            step();
        end
        ws_valid = 1'b0;
        w_ack = 1'b0;
        chk("full_visits", hv, 34);
        chk("full_setups", n_setup, 34);
        chk("full_done", done_cnt, 1);
        chk("full_err", err, 0);
        step();
        chk("full_done_pulse", done, 0);
        chk("full_idle_busy", busy, 0);

        // Timeout with valid stuck low
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("to_c0_load", ws_load, 1);
        repeat (15) step();
        chk("to_c15_load", ws_load, 1);
        chk("to_c15_busy", busy, 1);
        step();
        chk("to_busy", busy, 0);
        chk("to_err", err, 1);
        chk("to_load", ws_load, 0);
        chk("to_done", done, 0);
        step();
        chk("to_err_sticky", err, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_restart_err", err, 0);
        chk("to_restart_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_setup_busy", busy, 0);
        chk("abort_setup_err", err, 0);

        // Async reset in FETCH of L2p5
        start = 1'b1;
        step();
        start = 1'b0;
        lcnt = 0;
        rcnt = 0;
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            if (ws_load && !w_rdy && ws_cs == `LAYER2 && ws_phase == 3'd5) begin
                reached = 1;
                break;
            end
            model();
            step();
        end
        chk("reach_l2p5", reached, 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        ws_valid = 1'b0;
        w_ack = 1'b0;
        #2 rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_rst_setup_sel", {ws_cs, ws_phase}, {`LAYER0, 3'd0});
        step();
        chk("post_rst_fetch_load", ws_load, 1);
        chk("post_rst_fetch_sel", {ws_cs, ws_phase}, {`LAYER0, 3'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
